mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have inputs MemReadIn, MemWriteIn, MemtoRegIn, RegWriteIn, 1 bit each: control from EX/MEM register.
REQ-004 SHALL have input sizeIn, 2 bits: access size, 00 byte, 01 half, 10 word, 11 treated as word.
REQ-005 SHALL have input signedIn, 1 bit: 1 means sign-extend sub-word loads, 0 means zero-extend.
REQ-006 SHALL have inputs AluIn (32), writeDataIn (32) and writeRegIn (5): address/ALU result, store data, destination register.
REQ-007 SHALL have memory-side ports: memReq out 1, memWe out 1, memAddr out 32, memWData out 32, memBe out 4, memRData in 32, memAck in 1.
REQ-008 SHALL have outputs to MEM/WB: MemtoRegOut 1, RegWriteOut 1, AluOut 32, MemDataOut 32, writeRegOut 5.
REQ-009 SHALL have outputs stallOut 1 (freeze upstream pipeline), misalignOut 1, busErrOut 1.

Function
REQ-010 SHALL implement FSM with states IDLE, ACCESS, DONE.
REQ-011 An access is pending when (MemReadIn or MemWriteIn) is 1 and the address is aligned; MemWriteIn takes priority when both are set.
REQ-012 Aligned means: byte always; half requires AluIn[0]=0; word requires AluIn[1:0]=00.
REQ-013 IDLE with pending access: stallOut=1 combinationally; next state ACCESS; timeout counter cleared.
REQ-014 ACCESS: memReq=1, stallOut=1; memAddr={AluIn[31:2],2'b00}, memWe, memWData and memBe held stable until memAck.
REQ-015 ACCESS with memAck=1: memRData captured into an internal 32-bit register; next state DONE.
REQ-016 ACCESS timeout: 4-bit counter increments each ACCESS cycle without ack; on the 16th consecutive no-ack cycle, next state DONE with bus-error flag set; ack on that same cycle wins, no error.
REQ-017 DONE: stallOut=0; lasts exactly one cycle; next state IDLE. A new access cannot start until IDLE is re-entered.
REQ-018 memAck SHALL be ignored in IDLE and DONE.
REQ-019 Store lanes: byte replicates writeDataIn[7:0] to all four lanes, memBe=1 shifted left by AluIn[1:0]; half replicates [15:0], memBe=0011 if AluIn[1]=0 else 1100; word memBe=1111. Loads use memBe=1111, memWe=0.
REQ-020 Load extract (little-endian, byte k at bits 8k+7:8k): byte lane AluIn[1:0], half lane AluIn[1]; extended to 32 bits per signedIn.
REQ-021 MemDataOut SHALL be the extracted load value in DONE for a read with no bus error; 0 in all other cases.
REQ-022 AluOut, MemtoRegOut and writeRegOut SHALL pass through combinationally from AluIn, MemtoRegIn and writeRegIn.
REQ-023 RegWriteOut SHALL equal RegWriteIn, except forced to 0 when misalignOut=1 or busErrOut=1.
REQ-024 Misaligned memory op in IDLE: misalignOut=1 combinationally, no stall, no memReq, FSM stays IDLE.
REQ-025 busErrOut SHALL be 1 only in the DONE cycle following a timeout.
REQ-026 Non-memory instructions in IDLE: no stall, pure pass-through.

Reset
REQ-027 rst=1 at a clock edge SHALL set state IDLE, clear the counter, clear captured data and clear the error flag, from any state including mid-ACCESS.
REQ-028 While rst=1: memReq=0, stallOut=0, RegWriteOut=0, MemDataOut=0, misalignOut=0, busErrOut=0.

Verification
REQ-029 Zero-wait word load: lw AluIn=0x100, memAck=1 on first ACCESS cycle, memRData=0xDEADBEEF -> stallOut high 2 cycles; DONE gives MemDataOut=0xDEADBEEF, RegWriteOut=1.
REQ-030 Byte load: lb AluIn=0x103, signedIn=1, memRData=0x80112233, ack after 3 wait cycles -> MemDataOut=0xFFFFFF80 in DONE, stall 5 cycles; lbu -> 0x00000080.
REQ-031 Half store: sh AluIn=0x22, writeDataIn=0x1234ABCD -> memWData=0xABCDABCD, memBe=1100, memWe=1, MemDataOut=0.
REQ-032 Misaligned word load: lw AluIn=0x101 -> misalignOut=1, RegWriteOut=0, stallOut=0, memReq never asserted.
REQ-033 Timeout: lw with memAck held 0 -> 16 ACCESS cycles, then DONE with busErrOut=1, RegWriteOut=0, MemDataOut=0; repeat with ack on 16th cycle -> no error.
REQ-034 Reset mid-access: rst pulsed on 2nd ACCESS cycle -> next cycle IDLE, memReq=0, stallOut=0; late memAck ignored.

Source files
------------

// File: rtl/mem_access.sv
// Memory-stage access controller: aligns, issues and times out a single data-bus
// transaction per load/store, stalling the upstream pipeline until it completes.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadIn,
    input  logic        MemWriteIn,
    input  logic        MemtoRegIn,
    input  logic        RegWriteIn,
    input  logic [1:0]  sizeIn,
    input  logic        signedIn,
    input  logic [31:0] AluIn,
    input  logic [31:0] writeDataIn,
    input  logic [4:0]  writeRegIn,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    output logic [3:0]  memBe,
    input  logic [31:0] memRData,
    input  logic        memAck,
    output logic        MemtoRegOut,
    output logic        RegWriteOut,
    output logic [31:0] AluOut,
    output logic [31:0] MemDataOut,
    output logic [4:0]  writeRegOut,
    output logic        stallOut,
    output logic        misalignOut,
    output logic        busErrOut
);
    // state  | meaning
    // IDLE   | no transaction; aligned memory op stalls and launches one
    // ACCESS | memReq held until memAck or 16 cycles without ack
    // DONE   | one-cycle result slot for MEM/WB, pipeline released
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, nextState;
    logic [3:0]  toCnt;
    logic [31:0] rdataReg;
    logic        errFlag;
    logic        memOp, aligned, pending, isRead;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadVal;

    assign memOp   = MemReadIn | MemWriteIn;
    assign pending = memOp & aligned;
    assign isRead  = MemReadIn & ~MemWriteIn;

    always_comb begin
        aligned = 1'b1;
        case (sizeIn)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~AluIn[0];
            default: aligned = (AluIn[1:0] == 2'b00);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            toCnt    <= 4'd0;
            rdataReg <= 32'd0;
            errFlag  <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    toCnt   <= 4'd0;
                    errFlag <= 1'b0;
                end
                ACCESS: begin
                    if (memAck) begin
                        rdataReg <= memRData;
                    end else begin
                        toCnt <= toCnt + 4'd1;
                        if (toCnt == 4'hF) errFlag <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (pending) nextState = ACCESS;
            ACCESS:  if (memAck || toCnt == 4'hF) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Store lane steering; loads read the whole word and extract afterwards.
    always_comb begin
        memWData = writeDataIn;
        memBe    = 4'b1111;
        if (MemWriteIn) begin
            case (sizeIn)
                2'b00: begin
                    memWData = {4{writeDataIn[7:0]}};
                    memBe    = 4'b0001 << AluIn[1:0];
                end
                2'b01: begin
                    memWData = {2{writeDataIn[15:0]}};
                    memBe    = AluIn[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    memWData = writeDataIn;
                    memBe    = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        loadByte = rdataReg[7:0];
        case (AluIn[1:0])
            2'b00: loadByte = rdataReg[7:0];
            2'b01: loadByte = rdataReg[15:8];
            2'b10: loadByte = rdataReg[23:16];
            2'b11: loadByte = rdataReg[31:24];
        endcase
        loadHalf = AluIn[1] ? rdataReg[31:16] : rdataReg[15:0];
        case (sizeIn)
            2'b00:   loadVal = {{24{signedIn & loadByte[7]}}, loadByte};
            2'b01:   loadVal = {{16{signedIn & loadHalf[15]}}, loadHalf};
            default: loadVal = rdataReg;
        endcase
    end

    assign memAddr     = {AluIn[31:2], 2'b00};
    assign memReq      = ~rst & (state == ACCESS);
    assign memWe       = memReq & MemWriteIn;
    assign stallOut    = ~rst & (((state == IDLE) & pending) | (state == ACCESS));
    assign misalignOut = ~rst & (state == IDLE) & memOp & ~aligned;
    assign busErrOut   = ~rst & (state == DONE) & errFlag;
    assign RegWriteOut = ~rst & RegWriteIn & ~misalignOut & ~busErrOut;
    assign MemDataOut  = (~rst & (state == DONE) & isRead & ~errFlag) ? loadVal : 32'd0;

    assign AluOut      = AluIn;
    assign MemtoRegOut = MemtoRegIn;
    assign writeRegOut = writeRegIn;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: transaction-level expected waveform per cycle,
// checked on every falling edge, plus literal results for the headline cases.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadIn, MemWriteIn, MemtoRegIn, RegWriteIn;
    logic [1:0]  sizeIn;
    logic        signedIn;
    logic [31:0] AluIn, writeDataIn;
    logic [4:0]  writeRegIn;
    logic        memReq, memWe;
    logic [31:0] memAddr, memWData;
    logic [3:0]  memBe;
    logic [31:0] memRData;
    logic        memAck;
    logic        MemtoRegOut, RegWriteOut;
    logic [31:0] AluOut, MemDataOut;
    logic [4:0]  writeRegOut;
    logic        stallOut, misalignOut, busErrOut;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst),
        .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn), .MemtoRegIn(MemtoRegIn), .RegWriteIn(RegWriteIn),
        .sizeIn(sizeIn), .signedIn(signedIn), .AluIn(AluIn), .writeDataIn(writeDataIn), .writeRegIn(writeRegIn),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData), .memBe(memBe),
        .memRData(memRData), .memAck(memAck),
        .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut), .AluOut(AluOut), .MemDataOut(MemDataOut),
        .writeRegOut(writeRegOut), .stallOut(stallOut), .misalignOut(misalignOut), .busErrOut(busErrOut)
    );

    int nChecks = 0;
    int nFail   = 0;

    logic        chkEn = 1'b0;
    logic        eStall, eReq, eMis, eBus, eRegWr, isDone;
    logic [31:0] eData;
    logic [31:0] lastDoneData, lastWData;
    logic [3:0]  lastBe;
    logic        lastWe;
    int          stallSeen, reqSeen, busSeen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] modelLoad(input logic [1:0] sz, input logic sg,
                                              input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (rd >> (8 * addr[1:0])) & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (rd >> (16 * addr[1])) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] modelBe(input logic [1:0] sz, input logic wr, input logic [31:0] addr);
        logic [31:0] b;
        if (!wr || sz[1]) b = 32'hF;
        else if (sz == 2'b00) b = 32'h1 << addr[1:0];
        else b = addr[1] ? 32'hC : 32'h3;
        return b[3:0];
    endfunction

    function automatic logic [31:0] modelWData(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    always @(negedge clk) begin
        if (chkEn) begin
            chk("stallOut", stallOut, eStall);
            chk("memReq", memReq, eReq);
            chk("misalignOut", misalignOut, eMis);
            chk("busErrOut", busErrOut, eBus);
            chk("RegWriteOut", RegWriteOut, eRegWr);
            chk("MemDataOut", MemDataOut, eData);
            chk("AluOut", AluOut, AluIn);
            chk("MemtoRegOut", MemtoRegOut, MemtoRegIn);
            chk("writeRegOut", writeRegOut, writeRegIn);
            if (stallOut) stallSeen++;
            if (memReq) reqSeen++;
            if (busErrOut) busSeen++;
            if (eReq) begin
                chk("memAddr", memAddr, AluIn & 32'hFFFF_FFFC);
                chk("memWe", memWe, MemWriteIn);
                chk("memBe", memBe, modelBe(sizeIn, MemWriteIn, AluIn));
                if (MemWriteIn) chk("memWData", memWData, modelWData(sizeIn, writeDataIn));
                lastWData = memWData;
                lastBe    = memBe;
                lastWe    = memWe;
            end
            if (isDone) lastDoneData = MemDataOut;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setNop();
        MemReadIn = 0; MemWriteIn = 0; MemtoRegIn = 0; RegWriteIn = 0;
        sizeIn = 2'b10; signedIn = 0; AluIn = 32'h0000_0044; writeDataIn = 32'h0;
        writeRegIn = 5'd0; memAck = 0;
        eStall = 0; eReq = 0; eMis = 0; eBus = 0; eRegWr = 0; eData = 0; isDone = 0;
    endtask

    // ackAt: ACCESS cycle (1..16) carrying memAck; anything else means never ack.
    task automatic runAccess(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                             input logic regWr, input int ackAt);
        logic timedOut;
        timedOut   = (ackAt < 1 || ackAt > 16);
        MemReadIn  = rd; MemWriteIn = wr; MemtoRegIn = rd; RegWriteIn = regWr;
        sizeIn     = sz; signedIn = sg; AluIn = addr; writeDataIn = wd; writeRegIn = 5'd9;
        memRData   = rdata; memAck = 0;
        stallSeen  = 0; reqSeen = 0; busSeen = 0;
        eStall = 1; eReq = 0; eMis = 0; eBus = 0; eRegWr = regWr; eData = 0; isDone = 0;
        step();
        for (int k = 1; k <= 16; k++) begin
            eReq   = 1;
            memAck = (k == ackAt);
            step();
            if (k == ackAt) break;
        end
        memAck = 0;
        eStall = 0; eReq = 0; eBus = timedOut; eRegWr = regWr && !timedOut;
        eData  = (rd && !wr && !timedOut) ? modelLoad(sz, sg, addr, rdata) : 32'h0;
        isDone = 1;
        step();
        setNop();
        step();
    endtask

    initial begin
        setNop();
        memRData = 32'h0;
        lastDoneData = 32'h0; lastWData = 32'h0; lastBe = 4'h0; lastWe = 1'b0;
        stallSeen = 0; reqSeen = 0; busSeen = 0;
        // Reset with a misaligned, register-writing load on the inputs: everything gated.
        rst = 1; MemReadIn = 1; RegWriteIn = 1; AluIn = 32'h101;
        step();
        chkEn = 1;
        step();
        step();
        rst = 0;
        setNop();
        step();

        runAccess(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 1);
        chk("lw_stall_cycles", stallSeen, 2);
        chk("lw_data", lastDoneData, 32'hDEAD_BEEF);

        runAccess(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h8011_2233, 1, 4);
        chk("lb_stall_cycles", stallSeen, 5);
        chk("lb_data", lastDoneData, 32'hFFFF_FF80);
        runAccess(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h8011_2233, 1, 4);
        chk("lbu_data", lastDoneData, 32'h0000_0080);

        runAccess(0, 1, 2'b01, 0, 32'h22, 32'h1234_ABCD, 32'h5A5A_5A5A, 0, 1);
        chk("sh_wdata", lastWData, 32'hABCD_ABCD);
        chk("sh_be", lastBe, 4'b1100);
        chk("sh_we", lastWe, 1'b1);
        chk("sh_memdata", lastDoneData, 32'h0);

        runAccess(0, 1, 2'b00, 0, 32'h102, 32'h0000_0055, 32'h0, 0, 2);
        chk("sb_be", lastBe, 4'b0100);
        chk("sb_wdata", lastWData, 32'h5555_5555);
        runAccess(1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h8001_1234, 1, 3);
        chk("lh_data", lastDoneData, 32'hFFFF_8001);
        runAccess(1, 0, 2'b01, 0, 32'h100, 32'h0, 32'h8001_F234, 1, 1);
        chk("lhu_data", lastDoneData, 32'h0000_F234);
        runAccess(1, 0, 2'b11, 0, 32'h200, 32'h0, 32'h0BAD_F00D, 1, 2);
        chk("size11_data", lastDoneData, 32'h0BAD_F00D);
        runAccess(1, 1, 2'b10, 0, 32'h10, 32'hCAFE_0001, 32'h1111_2222, 0, 1);
        chk("both_store_we", lastWe, 1'b1);
        chk("both_memdata", lastDoneData, 32'h0);

        // Misaligned word load, then misaligned half store.
        stallSeen = 0; reqSeen = 0;
        MemReadIn = 1; MemtoRegIn = 1; RegWriteIn = 1; sizeIn = 2'b10; AluIn = 32'h101; writeRegIn = 5'd3;
        eMis = 1; eRegWr = 0;
        step();
        step();
        MemReadIn = 0; MemtoRegIn = 0; MemWriteIn = 1; sizeIn = 2'b01; AluIn = 32'h23;
        step();
        chk("misalign_req_count", reqSeen, 0);
        chk("misalign_stall_count", stallSeen, 0);
        setNop();
        step();

        runAccess(1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h7777_7777, 1, 0);
        chk("timeout_stall_cycles", stallSeen, 17);
        chk("timeout_buserr_cycles", busSeen, 1);
        chk("timeout_memdata", lastDoneData, 32'h0);
        runAccess(1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h7777_7777, 1, 16);
        chk("ack16_stall_cycles", stallSeen, 17);
        chk("ack16_buserr_cycles", busSeen, 0);
        chk("ack16_data", lastDoneData, 32'h7777_7777);

        // Reset on the second ACCESS cycle; the late ack must not restart anything.
        stallSeen = 0; reqSeen = 0;
        MemReadIn = 1; MemtoRegIn = 1; RegWriteIn = 1; sizeIn = 2'b10; AluIn = 32'h400;
        memRData = 32'h1234_5678;
        eStall = 1; eRegWr = 1;
        step();
        eReq = 1;
        step();
        rst = 1; MemReadIn = 0; MemtoRegIn = 0;
        eStall = 0; eReq = 0; eRegWr = 0;
        step();
        rst = 0; RegWriteIn = 0; memAck = 1;
        step();
        memAck = 0;
        step();
        chk("rst_mid_req_count", reqSeen, 1);
        chk("rst_mid_stall_count", stallSeen, 2);

        runAccess(1, 0, 2'b10, 0, 32'h404, 32'h0, 32'h0102_0304, 1, 2);
        chk("post_rst_data", lastDoneData, 32'h0102_0304);

        chkEn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
